// File: rtl/tea_pkg.sv
// Shared constants and state type for the TEA CBC controller and its helpers.
package tea_pkg;

    localparam int          BLK_W = 64;
    localparam int          KEY_W = 128;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } tea_cbc_state_t;

endpackage

// File: rtl/tea_cbc_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting on the core and flags the last allowed one.
module tea_cbc_wdog #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // r_cnt holds the number of WAIT cycles already completed
    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/tea_cbc_ctrl.sv
// CBC chaining controller driving one TEA core operation per 64-bit block.
// Optional watchdog abort in WAIT is enabled by defining TEA_CBC_TIMEOUT_EN.
module tea_cbc_ctrl
    import tea_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iv_load,
    input  logic              cfg_mode,
    input  logic [BLK_W-1:0]  iv,
    input  logic [KEY_W-1:0]  key,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BLK_W-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BLK_W-1:0]  m_data,
    output logic              core_start,
    output logic              core_mode,
    output logic [31:0]       core_v0,
    output logic [31:0]       core_v1,
    output logic [31:0]       core_k0,
    output logic [31:0]       core_k1,
    output logic [31:0]       core_k2,
    output logic [31:0]       core_k3,
    input  logic [31:0]       core_v0_out,
    input  logic [31:0]       core_v1_out,
    input  logic              core_done,
    output logic              busy,
    output logic              err
);

    if (2**TO_W <= TIMEOUT_CYCLES) begin : g_to_w_chk
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    tea_cbc_state_t   r_state, w_state_nxt;
    logic [BLK_W-1:0] r_chain, r_blk, r_m_data;
    logic [BLK_W-1:0] w_chain_eff, w_core_out;
    logic [31:0]      r_core_v0, r_core_v1;
    logic             r_mode, r_armed;
    logic             w_mode_eff, w_iv_load, w_accept, w_capture, w_timeout;

    // A same-cycle iv_load is visible to the block being accepted
    assign w_iv_load   = iv_load && (r_state == ST_IDLE);
    assign w_chain_eff = w_iv_load ? iv : r_chain;
    assign w_mode_eff  = w_iv_load ? cfg_mode : r_mode;
    assign w_accept    = s_valid && (r_state == ST_IDLE);
    assign w_capture   = (r_state == ST_WAIT) && r_armed && core_done;
    assign w_core_out  = {core_v0_out, core_v1_out};

`ifdef TEA_CBC_TIMEOUT_EN
    logic r_err;

    tea_cbc_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state == ST_START),
        .i_en      (r_state == ST_WAIT),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_iv_load) begin
            r_err <= 1'b0;
        end else if (w_timeout && !w_capture) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        core_start  = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) w_state_nxt = ST_START;
            end
            ST_START: begin
                core_start  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_capture)      w_state_nxt = ST_OUT;
                else if (w_timeout) w_state_nxt = ST_IDLE;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain   <= '0;
            r_blk     <= '0;
            r_m_data  <= '0;
            r_core_v0 <= '0;
            r_core_v1 <= '0;
            r_mode    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            if (w_iv_load) begin
                r_chain <= iv;
                r_mode  <= cfg_mode;
            end
            if (w_accept) begin
                r_blk <= s_data;
                {r_core_v0, r_core_v1} <= w_mode_eff ? s_data : (s_data ^ w_chain_eff);
            end
            // Arm only after done has been seen low, so a stale done is never taken
            if (r_state == ST_START) begin
                r_armed <= 1'b0;
            end else if ((r_state == ST_WAIT) && !core_done) begin
                r_armed <= 1'b1;
            end
            if (w_capture) begin
                if (r_mode) begin
                    r_m_data <= w_core_out ^ r_chain;
                    r_chain  <= r_blk;
                end else begin
                    r_m_data <= w_core_out;
                    r_chain  <= w_core_out;
                end
            end
        end
    end

    assign m_data    = r_m_data;
    assign core_mode = r_mode;
    assign core_v0   = r_core_v0;
    assign core_v1   = r_core_v1;
    assign core_k0   = key[127:96];
    assign core_k1   = key[95:64];
    assign core_k2   = key[63:32];
    assign core_k3   = key[31:0];

endmodule
